// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution block: address/count widths, the
// datapath sample/accumulator types and the sequencer state encoding.
// Optional build macro used by conv_sequencer: CONV_SEQ_PERF_EN.
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int CONV_XW  = 10;  // x/y address and sample-count width
  localparam int CONV_HW  = 6;   // h address width
  localparam int CONV_KW  = 3;   // tap-count width
  localparam int CONV_DW  = 8;   // signed sample / coefficient width
  localparam int CONV_ACW = 16;  // signed accumulator width

  typedef logic signed [CONV_DW-1:0]  conv_data_t;
  typedef logic signed [CONV_ACW-1:0] conv_acc_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5
  } conv_seq_state_t;

  // A compute is in progress from CLEAR through WRITE; FINISH is not busy.
  function automatic logic conv_is_busy(input conv_seq_state_t s);
    return (s == ST_CLEAR) || (s == ST_ISSUE) || (s == ST_DRAIN) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_addr_gen
// Output index (n) and tap index (k) counters for the convolution sequencer,
// together with the latched sample count (Ir) and tap count (Kr).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cfg_load          latch i_cfg/k_cfg into Ir/Kr
//   i_cfg, k_cfg      sample count / tap count to latch
//   n_clr, n_inc      clear / increment n
//   k_clr, k_inc      clear / increment k
//   n_out             current output index (y address)
//   tap_addr          k zero-extended to the h address width
//   samp_addr         n-k, the x address for the current tap
//   last_tap          current k is the final tap for this output
//   last_out          current n is the final output
// -----------------------------------------------------------------------------
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int XW = CONV_XW,
  parameter int HW = CONV_HW,
  parameter int KW = CONV_KW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [XW-1:0] i_cfg,
  input  logic [KW-1:0] k_cfg,
  input  logic          n_clr,
  input  logic          n_inc,
  input  logic          k_clr,
  input  logic          k_inc,
  output logic [XW-1:0] n_out,
  output logic [HW-1:0] tap_addr,
  output logic [XW-1:0] samp_addr,
  output logic          last_tap,
  output logic          last_out
);

  logic [XW-1:0] ir_reg;
  logic [KW-1:0] kr_reg;
  logic [XW-1:0] n_reg;
  logic [KW-1:0] k_reg;
  logic [XW-1:0] k_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_reg <= '0;
      kr_reg <= '0;
      n_reg  <= '0;
      k_reg  <= '0;
    end else begin
      if (cfg_load) begin
        ir_reg <= i_cfg;
        kr_reg <= k_cfg;
      end
      if (n_clr) begin
        n_reg <= '0;
      end else if (n_inc) begin
        n_reg <= n_reg + XW'(1);
      end
      if (k_clr) begin
        k_reg <= '0;
      end else if (k_inc) begin
        k_reg <= k_reg + KW'(1);
      end
    end
  end

  assign k_ext     = {{(XW-KW){1'b0}}, k_reg};
  assign n_out     = n_reg;
  assign tap_addr  = {{(HW-KW){1'b0}}, k_reg};
  // k never exceeds n, so the subtraction cannot wrap.
  assign samp_addr = n_reg - k_ext;
  // Taps for output n stop at min(Kr, n+1): either all taps used or x[0] reached.
  assign last_tap  = (k_reg == (kr_reg - KW'(1))) || (k_ext == n_reg);
  assign last_out  = (n_reg == (ir_reg - XW'(1)));

endmodule

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
// Control sequencer for the convolution datapath. In IDLE it steers streamed
// taps/samples into the h/x memories; on start it walks the causal truncated
// convolution y[n] = sum h[k]*x[n-k], n = 0..I-1, driving memory addresses,
// write enables and the accumulator controls, then pulses done.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   I, K                  sample and tap counts, sampled on accepted start
//   start                 compute request pulse
//   load_h, load_x        write strobes for the next h / x slot
//   addr_x, wr_en_x       x memory address / write enable
//   addr_h, wr_en_h       h memory address / write enable
//   addr_y, wr_en_y       y memory address / write enable
//   clear_acc, acc_en     accumulator clear / accumulate
//   busy, done            compute in progress / one-cycle completion pulse
//   perf_cycles           (only with CONV_SEQ_PERF_EN) compute cycle counter
// Build macro: CONV_SEQ_PERF_EN adds the perf_cycles counter and port.
// -----------------------------------------------------------------------------
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int XW = CONV_XW,
  parameter int HW = CONV_HW,
  parameter int KW = CONV_KW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] I,
  input  logic [KW-1:0] K,
  input  logic          start,
  input  logic          load_h,
  input  logic          load_x,
  output logic [XW-1:0] addr_x,
  output logic          wr_en_x,
  output logic [HW-1:0] addr_h,
  output logic          wr_en_h,
  output logic [XW-1:0] addr_y,
  output logic          wr_en_y,
  output logic          clear_acc,
  output logic          acc_en,
  output logic          busy,
  output logic          done
`ifdef CONV_SEQ_PERF_EN
  , output logic [19:0] perf_cycles
`endif
);

  conv_seq_state_t state_reg, state_next;

  logic [HW-1:0] hptr_reg, hptr_next;
  logic [XW-1:0] xptr_reg, xptr_next;
  logic          acc_en_reg;

  logic [HW:0]   hptr_inc, k_lim;
  logic [XW:0]   xptr_inc, i_lim;

  logic          h_wr, x_wr, start_ok;
  logic          cfg_load, n_clr, n_inc, k_clr, k_inc;
  logic [XW-1:0] n_cur, samp_addr;
  logic [HW-1:0] tap_addr;
  logic          last_tap, last_out;

  // Load steering. Gating with reset keeps the write enables low while reset
  // is held, even if a strobe is already active.
  assign h_wr     = reset && (state_reg == ST_IDLE) && load_h;
  assign x_wr     = reset && (state_reg == ST_IDLE) && load_x && !load_h;
  assign start_ok = (state_reg == ST_IDLE) && start && !load_h && !load_x;

  // Pointer wrap uses one extra bit so that a count shrunk below the current
  // pointer still wraps to 0 instead of running on.
  assign hptr_inc  = {1'b0, hptr_reg} + {{HW{1'b0}}, 1'b1};
  assign k_lim     = {{(HW+1-KW){1'b0}}, K};
  assign hptr_next = ((K == '0) || (hptr_inc >= k_lim)) ? '0 : hptr_inc[HW-1:0];

  assign xptr_inc  = {1'b0, xptr_reg} + {{XW{1'b0}}, 1'b1};
  assign i_lim     = {1'b0, I};
  assign xptr_next = ((I == '0) || (xptr_inc >= i_lim)) ? '0 : xptr_inc[XW-1:0];

  conv_addr_gen #(
    .XW(XW),
    .HW(HW),
    .KW(KW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .i_cfg     (I),
    .k_cfg     (K),
    .n_clr     (n_clr),
    .n_inc     (n_inc),
    .k_clr     (k_clr),
    .k_inc     (k_inc),
    .n_out     (n_cur),
    .tap_addr  (tap_addr),
    .samp_addr (samp_addr),
    .last_tap  (last_tap),
    .last_out  (last_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      hptr_reg   <= '0;
      xptr_reg   <= '0;
      acc_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (h_wr) begin
        hptr_reg <= hptr_next;
      end
      if (x_wr) begin
        xptr_reg <= xptr_next;
      end
      // Memory reads return one cycle after the ISSUE address.
      acc_en_reg <= (state_reg == ST_ISSUE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cfg_load   = 1'b0;
    n_clr      = 1'b0;
    n_inc      = 1'b0;
    k_clr      = 1'b0;
    k_inc      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          cfg_load   = 1'b1;
          n_clr      = 1'b1;
          state_next = ((I == '0) || (K == '0)) ? ST_FINISH : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        k_clr      = 1'b1;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (last_tap) begin
          state_next = ST_DRAIN;
        end else begin
          k_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_out) begin
          state_next = ST_FINISH;
        end else begin
          n_inc      = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign wr_en_h   = h_wr;
  assign wr_en_x   = x_wr;
  assign addr_h    = h_wr ? hptr_reg : ((state_reg == ST_ISSUE) ? tap_addr : '0);
  assign addr_x    = x_wr ? xptr_reg : ((state_reg == ST_ISSUE) ? samp_addr : '0);
  assign addr_y    = (state_reg == ST_WRITE) ? n_cur : '0;
  assign wr_en_y   = (state_reg == ST_WRITE);
  assign clear_acc = (state_reg == ST_CLEAR);
  assign acc_en    = acc_en_reg;
  assign busy      = conv_is_busy(state_reg);
  assign done      = (state_reg == ST_FINISH);

`ifdef CONV_SEQ_PERF_EN
  logic [19:0] perf_reg;

  // Counts elapsed cycles from the first to the last busy cycle of a run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reg <= '0;
    end else if (start_ok) begin
      perf_reg <= '0;
    end else if (conv_is_busy(state_reg) && conv_is_busy(state_next)) begin
      perf_reg <= perf_reg + 20'd1;
    end
  end

  assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;

  localparam int XW = 10;
  localparam int HW = 6;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [XW-1:0] I = '0;
  logic [KW-1:0] K = '0;
  logic          start = 1'b0;
  logic          load_h = 1'b0;
  logic          load_x = 1'b0;
  logic [XW-1:0] addr_x;
  logic          wr_en_x;
  logic [HW-1:0] addr_h;
  logic          wr_en_h;
  logic [XW-1:0] addr_y;
  logic          wr_en_y;
  logic          clear_acc;
  logic          acc_en;
  logic          busy;
  logic          done;
`ifdef CONV_SEQ_PERF_EN
  logic [19:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  conv_sequencer #(.XW(XW), .HW(HW), .KW(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .I         (I),
    .K         (K),
    .start     (start),
    .load_h    (load_h),
    .load_x    (load_x),
    .addr_x    (addr_x),
    .wr_en_x   (wr_en_x),
    .addr_h    (addr_h),
    .wr_en_h   (wr_en_h),
    .addr_y    (addr_y),
    .wr_en_y   (wr_en_y),
    .clear_acc (clear_acc),
    .acc_en    (acc_en),
    .busy      (busy),
    .done      (done)
`ifdef CONV_SEQ_PERF_EN
    , .perf_cycles (perf_cycles)
`endif
  );

  // Datapath model: memories with one-cycle registered read and accumulator.
  int data_in = 0;
  int h_mem [0:63];
  int x_mem [0:1023];
  int y_mem [0:1023];
  int h_q = 0, x_q = 0, acc = 0, ah_q = 0, ax_q = 0;

  always @(posedge clk) begin
    h_q  <= h_mem[addr_h];
    x_q  <= x_mem[addr_x];
    ah_q <= int'(addr_h);
    ax_q <= int'(addr_x);
    if (clear_acc) acc <= 0;
    else if (acc_en) acc <= acc + h_q * x_q;
    if (wr_en_h) h_mem[addr_h] <= data_in;
    if (wr_en_x) x_mem[addr_x] <= data_in;
    if (wr_en_y) y_mem[addr_y] <= acc;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {31'd0, addr_x, wr_en_x, addr_h, wr_en_h, addr_y, wr_en_y,
            clear_acc, acc_en, busy, done};
  endfunction

  function automatic logic [63:0] ld(input bit weh, input int ah, input bit wex, input int ax);
    return {46'd0, weh, ah[5:0], wex, ax[9:0]};
  endfunction

  task automatic strobe(input string tag, input bit lh, input bit lx, input int d,
                        input logic [63:0] exp);
    @(negedge clk);
    load_h  = lh;
    load_x  = lx;
    data_in = d;
    #1;
    $display("load %s h=%0b x=%0b d=%0d addr_h=%0d addr_x=%0d", tag, lh, lx, d, addr_h, addr_x);
    check(tag, {46'd0, wr_en_h, addr_h, wr_en_x, addr_x}, exp);
  endtask

  task automatic strobe_off();
    @(negedge clk);
    load_h = 1'b0;
    load_x = 1'b0;
  endtask

  int pr_q[$];
  int wr_q[$];

  // Issue start, then watch 40 cycles. e is the number of edges since the
  // edge that accepted start. Optional injections at given e values.
  task automatic run(input int i_v, input int k_v, input int inj_start, input int inj_lx,
                     input int inj_rst, output int lat, output int n_done, output bit saw_busy);
    pr_q.delete();
    wr_q.delete();
    lat = -1;
    n_done = 0;
    saw_busy = 1'b0;
    for (int j = 0; j < 16; j++) y_mem[j] = -1;
    @(negedge clk);
    I = XW'(i_v);
    K = KW'(k_v);
    start = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      start  = (e == inj_start);
      load_x = (e == inj_lx);
      reset  = (e != inj_rst);
      #1;
      if (e == inj_rst) check("rst_outs", outs(), 64'd0);
      if (e == inj_lx) check("lx_ignored", {63'd0, wr_en_x}, 64'd0);
      if (e > inj_rst) begin
        if (done) begin
          n_done++;
          if (lat < 0) lat = e;
        end
        if (wr_en_y) wr_q.push_back(int'(addr_y));
        if (acc_en) pr_q.push_back(ah_q * 1024 + ax_q);
      end
      if (busy) saw_busy = 1'b1;
    end
    start  = 1'b0;
    load_x = 1'b0;
    $display("run I=%0d K=%0d lat=%0d dones=%0d writes=%0d busy_seen=%0b",
             i_v, k_v, lat, n_done, wr_q.size(), saw_busy);
  endtask

  task automatic check_full_run(input string tag, input int lat, input int n_done);
    int ey [4] = '{1, 3, 6, 6};
    check({tag, "_lat"}, 64'(lat), 64'd21);
    check({tag, "_ndone"}, 64'(n_done), 64'd1);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      check({tag, "_y"}, 64'(y_mem[j]), 64'(ey[j]));
    end
  endtask

  int  eh [9] = '{0, 0, 1, 0, 1, 2, 0, 1, 2};
  int  ex [9] = '{0, 1, 0, 2, 1, 0, 3, 2, 1};
  int  lat, nd;
  bit  sb;

  initial begin
    for (int j = 0; j < 64; j++) h_mem[j] = 0;
    for (int j = 0; j < 1024; j++) begin
      x_mem[j] = 0;
      y_mem[j] = 0;
    end

    // Reset held with a load strobe active: every output must stay 0.
    load_h = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    load_h = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    #1;
    check("idle_outs", outs(), 64'd0);

    // Load taps {1,2,3} and samples {1,1,1,1}.
    I = 10'd4;
    K = 3'd3;
    strobe("ld_h0", 1'b1, 1'b0, 1, ld(1'b1, 0, 1'b0, 0));
    strobe("ld_h1", 1'b1, 1'b0, 2, ld(1'b1, 1, 1'b0, 0));
    strobe("ld_h2", 1'b1, 1'b0, 3, ld(1'b1, 2, 1'b0, 0));
    for (int j = 0; j < 4; j++) strobe("ld_x", 1'b0, 1'b1, 1, ld(1'b0, 0, 1'b1, j));
    strobe_off();

    // Main compute I=4, K=3.
    run(4, 3, -1, -1, -1, lat, nd, sb);
    check_full_run("main", lat, nd);
    check("main_busy", {63'd0, sb}, 64'd1);
    for (int j = 0; j < 4; j++) check("main_waddr", 64'(j < wr_q.size() ? wr_q[j] : -1), 64'(j));
    check("main_npairs", 64'(pr_q.size()), 64'd9);
    for (int j = 0; j < 9; j++)
      check("main_pair", 64'(j < pr_q.size() ? pr_q[j] : -1), 64'(eh[j] * 1024 + ex[j]));
`ifdef CONV_SEQ_PERF_EN
    check("perf", 64'(perf_cycles), 64'd20);
`endif

    // Both strobes together: h goes to slots 0,1; x pointer stays at 0.
    strobe("both0", 1'b1, 1'b1, 1, ld(1'b1, 0, 1'b0, 0));
    strobe("both1", 1'b1, 1'b1, 2, ld(1'b1, 1, 1'b0, 0));
    strobe("xptr_keep", 1'b0, 1'b1, 1, ld(1'b0, 0, 1'b1, 0));
    strobe_off();

    // K=0: immediate done, nothing written, never busy.
    run(4, 0, -1, -1, -1, lat, nd, sb);
    check("k0_lat", 64'(lat), 64'd0);
    check("k0_ndone", 64'(nd), 64'd1);
    check("k0_nwr", 64'(wr_q.size()), 64'd0);
    check("k0_busy", {63'd0, sb}, 64'd0);

    // Stray start and load_x during compute are ignored.
    run(4, 3, 6, 9, -1, lat, nd, sb);
    check_full_run("stray", lat, nd);
    strobe("xptr_after", 1'b0, 1'b1, 1, ld(1'b0, 0, 1'b1, 1));
    strobe_off();

    // Reset while in ISSUE (n=1): aborted, no done and no y writes after it.
    run(8, 3, -1, -1, 6, lat, nd, sb);
    check("abort_ndone", 64'(nd), 64'd0);
    check("abort_nwr", 64'(wr_q.size()), 64'd0);

    // A following start runs normally.
    run(4, 3, -1, -1, -1, lat, nd, sb);
    check_full_run("rerun", lat, nd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
